// File: rtl/hdmux_pkg.sv
// Shared types and constants for the registered N:1 mux.
// Holds the select FSM encoding and the sizing helper.
package hdmux_pkg;

    typedef enum logic [1:0] {
        RUN,
        GAP_WAIT,
        LOAD
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int CW = clog2(16);

endpackage

// File: rtl/hdmux_sel_ctrl.sv
// Select handshake FSM: break-before-make gap, pending select,
// ready and out-of-range error pulse.
module hdmux_sel_ctrl
    import hdmux_pkg::*;
#(
    parameter int N   = 4,
    parameter int GAP = 1,
    parameter int SW  = clog2(N)
) (
    input  logic          CK,
    input  logic          RST,
    input  logic [SW-1:0] SL_REQ,
    input  logic          SL_VLD,
    output logic          SL_RDY,
    output logic [SW-1:0] SL_CUR,
    output logic          ERR
);

    localparam logic [SW:0]   NV     = (SW + 1)'(N);
    localparam logic [CW-1:0] GAP_M1 = CW'((GAP > 0) ? GAP - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] pend;
    logic          bad_req;

    assign bad_req = {1'b0, SL_REQ} >= NV;

    always_ff @(posedge CK) begin
        if (RST) begin
            state  <= RUN;
            cnt    <= '0;
            pend   <= '0;
            SL_CUR <= '0;
            SL_RDY <= 1'b1;
            ERR    <= 1'b0;
        end else begin
            ERR <= 1'b0;
            unique case (state)
                RUN: begin
                    // SL_RDY is high throughout RUN, so SL_VLD alone accepts
                    if (SL_VLD) begin
                        if (bad_req) begin
                            ERR <= 1'b1;
                        end else if (SL_REQ != SL_CUR) begin
                            pend   <= SL_REQ;
                            SL_RDY <= 1'b0;
                            if (GAP > 0) begin
                                cnt   <= GAP_M1;
                                state <= GAP_WAIT;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                GAP_WAIT: begin
                    if (cnt == '0) begin
                        state <= LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LOAD: begin
                    SL_CUR <= pend;
                    SL_RDY <= 1'b1;
                    state  <= RUN;
                end
                default: begin
                    state  <= RUN;
                    SL_RDY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/hdmuxb_n_reg.sv
// Registered N:1 word mux with optional inversion; select
// changes are gated through hdmux_sel_ctrl.
module hdmuxb_n_reg
    import hdmux_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter bit INV = 1'b1,
    parameter int GAP = 1,
    parameter int SW  = clog2(N)
) (
    input  logic           CK,
    input  logic           RST,
    input  logic [N*W-1:0] A,
    input  logic           EN,
    input  logic [SW-1:0]  SL_REQ,
    input  logic           SL_VLD,
    output logic           SL_RDY,
    output logic [SW-1:0]  SL_CUR,
    output logic [W-1:0]   Z,
    output logic           ZV,
    output logic           ERR
);

    logic [W-1:0] sel_w;
    logic         cap;

    hdmux_sel_ctrl #(
        .N  (N),
        .GAP(GAP),
        .SW (SW)
    ) u_ctrl (
        .CK    (CK),
        .RST   (RST),
        .SL_REQ(SL_REQ),
        .SL_VLD(SL_VLD),
        .SL_RDY(SL_RDY),
        .SL_CUR(SL_CUR),
        .ERR   (ERR)
    );

    always_comb begin
        sel_w = '0;
        for (int i = 0; i < N; i++) begin
            if (SL_CUR == SW'(i)) begin
                sel_w = A[i*W +: W];
            end
        end
    end

    // SL_RDY doubles as "in RUN": capture is frozen during a switch
    assign cap = EN && SL_RDY;

    always_ff @(posedge CK) begin
        if (RST) begin
            Z  <= {W{INV}};
            ZV <= 1'b0;
        end else begin
            ZV <= cap;
            if (cap) begin
                Z <= INV ? ~sel_w : sel_w;
            end
        end
    end

endmodule

// File: tb/tb_hdmuxb_n_reg.sv
// Bench: two configurations of hdmuxb_n_reg against a cycle-count
// reference model, directed steps followed by random traffic.
module tb_hdmuxb_n_reg;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] A0 = '0;
    logic        EN = 1'b0;
    logic [1:0]  SL_REQ = '0;
    logic        SL_VLD = 1'b0;

    logic        rdy0, zv0, err0;
    logic [1:0]  cur0;
    logic [7:0]  z0;
    logic        rdy1, zv1, err1;
    logic [1:0]  cur1;
    logic [7:0]  z1;
    logic [23:0] A1;

    int n_chk = 0;
    int n_fail = 0;

    assign A1 = A0[23:0];

    always #5 CK = ~CK;

    hdmuxb_n_reg #(.N(4), .W(8), .INV(1'b1), .GAP(2)) dut0 (
        .CK(CK), .RST(RST), .A(A0), .EN(EN),
        .SL_REQ(SL_REQ), .SL_VLD(SL_VLD), .SL_RDY(rdy0),
        .SL_CUR(cur0), .Z(z0), .ZV(zv0), .ERR(err0)
    );

    hdmuxb_n_reg #(.N(3), .W(8), .INV(1'b0), .GAP(0)) dut1 (
        .CK(CK), .RST(RST), .A(A1), .EN(EN),
        .SL_REQ(SL_REQ), .SL_VLD(SL_VLD), .SL_RDY(rdy1),
        .SL_CUR(cur1), .Z(z1), .ZV(zv1), .ERR(err1)
    );

    // wt = cycles still unavailable after an accepted switch
    typedef struct {
        int         cur;
        int         pend;
        int         wt;
        logic [7:0] z;
        logic       zv;
        logic       err;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t step(mdl_t m, int n, bit inv, int gap,
                                  logic [31:0] a, logic rst, logic en,
                                  logic vld, logic [1:0] req);
        mdl_t r;
        logic [7:0] w;
        r = m;
        if (rst) begin
            r.cur = 0; r.pend = 0; r.wt = 0;
            r.z = inv ? 8'hFF : 8'h00;
            r.zv = 0; r.err = 0;
        end else if (m.wt == 0) begin
            w = a[m.cur*8 +: 8];
            r.zv = en;
            r.err = 0;
            if (en) r.z = inv ? ~w : w;
            if (vld) begin
                if (int'(req) >= n) r.err = 1;
                else if (int'(req) != m.cur) begin
                    r.pend = int'(req);
                    r.wt = gap + 1;
                end
            end
        end else begin
            r.zv = 0; r.err = 0;
            r.wt = m.wt - 1;
            if (r.wt == 0) r.cur = m.pend;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        m0 = step(m0, 4, 1'b1, 2, A0, RST, EN, SL_VLD, SL_REQ);
        m1 = step(m1, 3, 1'b0, 0, {8'h00, A1}, RST, EN, SL_VLD, SL_REQ);
        #1;
        chk("d0_z", z0, m0.z);
        chk("d0_zv", zv0, m0.zv);
        chk("d0_err", err0, m0.err);
        chk("d0_rdy", rdy0, m0.wt == 0);
        chk("d0_cur", cur0, m0.cur);
        chk("d1_z", z1, m1.z);
        chk("d1_zv", zv1, m1.zv);
        chk("d1_err", err1, m1.err);
        chk("d1_rdy", rdy1, m1.wt == 0);
        chk("d1_cur", cur1, m1.cur);
    endtask

    initial begin
        // reset values
        RST = 1'b1;
        tick(); tick();
        chk("rst_z0", z0, 8'hFF);
        chk("rst_z1", z1, 8'h00);
        chk("rst_zv0", zv0, 1'b0);
        chk("rst_cur0", cur0, 2'd0);
        chk("rst_rdy0", rdy0, 1'b1);

        // capture select 0
        RST = 1'b0;
        A0 = 32'h44332211;
        EN = 1'b1;
        tick();
        chk("cap_inv", z0, 8'hEE);
        chk("cap_zv", zv0, 1'b1);
        chk("cap_true", z1, 8'h11);

        // switch to 2 with EN high: accept edge captures old select
        SL_REQ = 2'd2;
        SL_VLD = 1'b1;
        tick();
        chk("acc_z", z0, 8'hEE);
        chk("acc_rdy", rdy0, 1'b0);
        SL_VLD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_zv", zv0, 1'b0);
            chk("gap_z", z0, 8'hEE);
        end
        chk("sw_cur", cur0, 2'd2);
        tick();
        chk("sw_z", z0, 8'hCC);
        chk("sw_zv", zv0, 1'b1);

        // same-select request: no gap
        SL_VLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("same_zv", zv0, 1'b1);
            chk("same_rdy", rdy0, 1'b1);
        end

        // select 3: legal for N=4, rejected for N=3
        SL_REQ = 2'd3;
        tick();
        chk("oor_err", err1, 1'b1);
        chk("oor_cur", cur1, 2'd2);
        SL_VLD = 1'b0;
        tick();
        chk("oor_err_off", err1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("sw3_cur", cur0, 2'd3);

        // back to 0, then simultaneous capture + switch to 1
        SL_REQ = 2'd0;
        SL_VLD = 1'b1;
        tick();
        SL_VLD = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        SL_REQ = 2'd1;
        SL_VLD = 1'b1;
        tick();
        chk("sim_z0", z0, 8'hEE);
        chk("sim_z1", z1, 8'h11);
        SL_VLD = 1'b0;
        tick();
        chk("g0_load_zv", zv1, 1'b0);
        tick();
        chk("g0_cur", cur1, 2'd1);
        for (int i = 0; i < 4; i++) tick();

        // reset during GAP_WAIT
        SL_REQ = 2'd2;
        SL_VLD = 1'b1;
        tick();
        SL_VLD = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_cur", cur0, 2'd0);
        chk("mid_rdy", rdy0, 1'b1);
        tick();
        chk("mid_cur2", cur0, 2'd0);
        chk("mid_rdy2", rdy0, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            A0 = $urandom;
            EN = ($urandom_range(3) != 0);
            SL_VLD = ($urandom_range(2) == 0);
            SL_REQ = 2'($urandom_range(3));
            RST = ($urandom_range(63) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
